// File: rtl/i2c_pkg.sv
// Shared I2C slave types and constants: transmit sequencer states, ACK/NACK
// bus levels and the default byte sent when the TX FIFO runs dry.
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      ACK_WAIT = 2'd2,
      ACK_HOLD = 2'd3
   } tx_state_t;

   localparam logic       ACK_BIT           = 1'b0;
   localparam logic       NACK_BIT          = 1'b1;
   localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover value;
// rollover_flag is high while count_out equals rollover_val.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic                    flag_q, flag_d;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   always_comb begin
      count_d = count_q;
      flag_d  = flag_q;
      if (clear) begin
         count_d = '0;
         flag_d  = 1'b0;
      end else if (count_enable) begin
         if (count_q == rollover_val) count_d = NUM_CNT_BITS'(1);
         else                         count_d = count_q + NUM_CNT_BITS'(1);
         flag_d = (count_d == rollover_val);
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = flag_q;

endmodule

// File: rtl/i2c_tx_timer.sv
// Slave-side I2C read sequencer: shifts FIFO bytes MSB-first onto SDA and
// handles the master ACK/NACK. Define I2C_TX_UNDERFLOW_EN to add tx_underflow.
module i2c_tx_timer
   import i2c_pkg::*;
#(
   parameter int unsigned          DATA_W    = 8,
   parameter logic [DATA_W-1:0]    FILL_BYTE = DATA_W'(DEFAULT_FILL_BYTE)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start_found,
   input  logic              stop_found,
   input  logic              rising_edge_found,
   input  logic              falling_edge_found,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              sda_in,
   output logic              sda_out,
   output logic              sda_oe,
   output logic              byte_sent,
   output logic              master_ack,
   output logic              master_nack,
`ifdef I2C_TX_UNDERFLOW_EN
   output logic              tx_underflow,
`endif
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              ack_q, ack_d;
   logic              tx_ready_q, tx_ready_d;
   logic              byte_sent_q, byte_sent_d;
   logic              master_ack_q, master_ack_d;
   logic              master_nack_q, master_nack_d;
   logic              sda_out_q, sda_out_d;
   logic              sda_oe_q, sda_oe_d;
   logic              busy_q, busy_d;
`ifdef I2C_TX_UNDERFLOW_EN
   logic              underflow_q, underflow_d;
`endif

   logic              abort;
   logic              load;
   logic              bit_last;
   logic [CNT_W-1:0]  bit_cnt;
   logic              cnt_rollover;

   assign abort = start_found | stop_found;

   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (load | abort),
      .count_enable  ((state_q == SHIFT) & falling_edge_found),
      .rollover_val  (CNT_W'(DATA_W)),
      .count_out     (bit_cnt),
      .rollover_flag (cnt_rollover)
   );

   // Rollover can only follow the last bit; treating it as last keeps a bad count from overrunning.
   assign bit_last = (bit_cnt == CNT_W'(DATA_W - 1)) | cnt_rollover;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         shift_q       <= FILL_BYTE;
         ack_q         <= 1'b0;
         tx_ready_q    <= 1'b0;
         byte_sent_q   <= 1'b0;
         master_ack_q  <= 1'b0;
         master_nack_q <= 1'b0;
         sda_out_q     <= 1'b1;
         sda_oe_q      <= 1'b0;
         busy_q        <= 1'b0;
`ifdef I2C_TX_UNDERFLOW_EN
         underflow_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         ack_q         <= ack_d;
         tx_ready_q    <= tx_ready_d;
         byte_sent_q   <= byte_sent_d;
         master_ack_q  <= master_ack_d;
         master_nack_q <= master_nack_d;
         sda_out_q     <= sda_out_d;
         sda_oe_q      <= sda_oe_d;
         busy_q        <= busy_d;
`ifdef I2C_TX_UNDERFLOW_EN
         underflow_q   <= underflow_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      ack_d         = ack_q;
      load          = 1'b0;
      tx_ready_d    = 1'b0;
      byte_sent_d   = 1'b0;
      master_ack_d  = 1'b0;
      master_nack_d = 1'b0;
`ifdef I2C_TX_UNDERFLOW_EN
      underflow_d   = 1'b0;
`endif

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tx_start) load = 1'b1;
            end
            SHIFT: begin
               if (falling_edge_found) begin
                  if (bit_last) begin
                     byte_sent_d = 1'b1;
                     state_d     = ACK_WAIT;
                  end else begin
                     shift_d = {shift_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
            ACK_WAIT: begin
               // A rising edge coincident with a falling edge is illegal and dropped.
               if (rising_edge_found && !falling_edge_found) begin
                  ack_d         = (sda_in == ACK_BIT);
                  master_ack_d  = (sda_in == ACK_BIT);
                  master_nack_d = (sda_in == NACK_BIT);
                  state_d       = ACK_HOLD;
               end
            end
            ACK_HOLD: begin
               if (falling_edge_found) begin
                  if (ack_q) load = 1'b1;
                  else       state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (load) begin
            state_d    = SHIFT;
            shift_d    = tx_valid ? tx_data : FILL_BYTE;
            tx_ready_d = tx_valid;
`ifdef I2C_TX_UNDERFLOW_EN
            underflow_d = ~tx_valid;
`endif
         end
      end

      // Pin values are registered from the next state so they track the Moore decode.
      sda_oe_d  = (state_d == SHIFT);
      sda_out_d = (state_d == SHIFT) ? shift_d[DATA_W-1] : 1'b1;
      busy_d    = (state_d != IDLE);
   end

   assign tx_ready    = tx_ready_q;
   assign byte_sent   = byte_sent_q;
   assign master_ack  = master_ack_q;
   assign master_nack = master_nack_q;
   assign sda_out     = sda_out_q;
   assign sda_oe      = sda_oe_q;
   assign busy        = busy_q;
`ifdef I2C_TX_UNDERFLOW_EN
   assign tx_underflow = underflow_q;
`endif

endmodule
